// File: rtl/requant_relu_stage_pkg.sv
// Shared definitions for the requantize/ReLU stage: op codes shared with the
// convolver, datapath widths and the bias/rounding arithmetic helpers.
package requant_relu_stage_pkg;

    localparam int CONV_OUT_W = 20;
    localparam int PIX_W      = 8;
    localparam int BIAS_W     = 21;
    localparam int SHIFT_W    = 5;
    localparam int SUM_W      = 22;
    localparam int VAL_W      = SUM_W - 1;
    localparam int RND_W      = 23;
    localparam int SAT_W      = 16;

    typedef enum logic [1:0] {
        CONV3X3    = 2'd0,
        MAXPOOL2X2 = 2'd1,
        OP_RSVD2   = 2'd2,
        OP_RSVD3   = 2'd3
    } op_e;

    // A non-negative sum of a 20-bit value and a 21-bit bias always fits in 21 bits.
    function automatic logic [VAL_W-1:0] bias_relu(
        input logic [CONV_OUT_W-1:0] pix,
        input logic [BIAS_W-1:0]     b
    );
        logic signed [SUM_W-1:0] sum;
        sum = $signed({2'b00, pix}) + $signed({b[BIAS_W-1], b});
        return sum[SUM_W-1] ? '0 : sum[VAL_W-1:0];
    endfunction

    function automatic logic [RND_W-1:0] round_shift(
        input logic [VAL_W-1:0]   val,
        input logic [SHIFT_W-1:0] sh
    );
        logic [RND_W-1:0] ext;
        logic [RND_W-1:0] half;
        ext = {2'b00, val};
        if (sh == '0) begin
            return ext;
        end
        if (sh >= SHIFT_W'(22)) begin
            return '0;
        end
        half = RND_W'(1) << (sh - SHIFT_W'(1));
        return (ext + half) >> sh;
    endfunction

endpackage

// File: rtl/requant_relu_stage_frame_pos_counter.sv
// Column/row position of the beat currently on the output, with end-of-line
// and end-of-frame decode. Advances only when the output beat is taken.
module frame_pos_counter #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic beat_valid,
    input  logic beat_taken,
    output logic eol,
    output logic eof
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col;
    logic             last_row;

    assign last_col = (col == COL_W'(IMAGE_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMAGE_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (beat_valid && beat_taken) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign eol = beat_valid && last_col;
    assign eof = eol && last_row;

endmodule

// File: rtl/requant_relu_stage.sv
// Bias + ReLU + rounding shift + 8-bit saturation on the convolver stream,
// in a 2-stage valid/ready pipeline with framing tags and a saturation counter.
module requant_relu_stage
    import requant_relu_stage_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CONV_OUT_W-1:0] pixel_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            operation,
    input  logic [BIAS_W-1:0]     bias,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  clear_stats,
    output logic [PIX_W-1:0]      pixel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic [SAT_W-1:0]      sat_count
);

    logic               s1_valid;
    logic [VAL_W-1:0]   s1_val;
    op_e                s1_op;
    logic [SHIFT_W-1:0] s1_shift;

    logic               s2_sat;
    logic               s1_advance;
    logic               s2_advance;

    logic [VAL_W-1:0]   s1_val_next;
    logic [RND_W-1:0]   rounded;
    logic [PIX_W-1:0]   s2_pix_next;
    logic               s2_sat_next;

    // in_ready depends combinationally on out_ready so a full pipe still streams.
    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    always_comb begin
        s1_val_next = '0;
        case (op_e'(operation))
            CONV3X3:    s1_val_next = bias_relu(pixel_in, bias);
            MAXPOOL2X2: s1_val_next = {1'b0, pixel_in};
            default:    s1_val_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_op    <= CONV3X3;
            s1_shift <= '0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_val   <= s1_val_next;
                s1_op    <= op_e'(operation);
                s1_shift <= shift;
            end
        end
    end

    // Reserved ops arrive with s1_val = 0 and fall through the conv path harmlessly.
    always_comb begin
        rounded     = '0;
        s2_pix_next = '0;
        s2_sat_next = 1'b0;
        if (s1_op == MAXPOOL2X2) begin
            s2_sat_next = (s1_val > VAL_W'(255));
            s2_pix_next = s2_sat_next ? 8'hFF : s1_val[PIX_W-1:0];
        end else begin
            rounded     = round_shift(s1_val, s1_shift);
            s2_sat_next = (rounded > RND_W'(255));
            s2_pix_next = s2_sat_next ? 8'hFF : rounded[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pixel_out <= '0;
            s2_sat    <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                pixel_out <= s2_pix_next;
                s2_sat    <= s2_sat_next;
            end
        end
    end

    // Counted at the output handshake, so a stalled beat is only counted once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (clear_stats) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && s2_sat && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_W'(1);
        end
    end

    frame_pos_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT)
    ) u_frame_pos (
        .clk       (clk),
        .rst       (rst),
        .beat_valid(out_valid),
        .beat_taken(out_ready),
        .eol       (out_eol),
        .eof       (out_eof)
    );

endmodule

// File: tb/tb_requant_relu_stage.sv
// Scoreboard bench for requant_relu_stage: stimulus pushes model results into a
// queue, a monitor pops and compares at every output handshake.
module tb_requant_relu_stage;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] pixel_in;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  operation;
    logic [20:0] bias;
    logic [4:0]  shift;
    logic        clear_stats;
    logic [7:0]  pixel_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_eol;
    logic        out_eof;
    logic [15:0] sat_count;

    typedef struct {
        int pix;
        bit sat;
        bit eol;
        bit eof;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   beat_idx   = 0;
    int   model_sat  = 0;
    int   eol_seen   = 0;
    int   eof_seen   = 0;
    bit   mon_flag;
    bit   stop_random = 1'b0;

    requant_relu_stage #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .bias       (bias),
        .shift      (shift),
        .clear_stats(clear_stats),
        .pixel_out  (pixel_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Plain-arithmetic reference: bias, clamp at zero, round-half-up divide, cap at 255.
    function automatic void ref_model(input int pix, input int op, input int b, input int sh,
                                      output int q, output bit sat);
        longint v;
        if (op == 0) begin
            v = longint'(pix) + longint'(b);
            if (v < 0) v = 0;
            if (sh != 0) v = (v + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
            sat = (v > 255);
            q   = sat ? 255 : int'(v);
        end else if (op == 1) begin
            sat = (pix > 255);
            q   = sat ? 255 : pix;
        end else begin
            sat = 1'b0;
            q   = 0;
        end
    endfunction

    task automatic applyStimulus(input int pix, input int op, input int b, input int sh);
        int   q;
        bit   sat;
        bit   taken;
        int   budget;
        exp_t e;
        taken  = 1'b0;
        budget = 0;
        ref_model(pix, op, b, sh, q, sat);
        pixel_in  = pix[19:0];
        operation = op[1:0];
        bias      = b[20:0];
        shift     = sh[4:0];
        in_valid  = 1'b1;
        while (!taken) begin
            @(negedge clk);
            if (in_ready) begin
                e.pix = q;
                e.sat = sat;
                e.eol = ((beat_idx % W) == W - 1);
                e.eof = e.eol && (((beat_idx / W) % H) == H - 1);
                sb.push_back(e);
                beat_idx++;
                taken = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!taken) begin
                budget++;
                if (budget > 200) begin
                    checkOutput("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic applyAndWatch(input string name, input int pix, input int op, input int b,
                                 input int sh, input int required);
        int budget;
        budget = 0;
        applyStimulus(pix, op, b, sh);
        @(negedge clk);
        while (!out_valid && budget < 5) begin
            @(negedge clk);
            budget++;
        end
        checkOutput(name, pixel_out, required);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        beat_idx = 0;
        rst      = 1'b0;
    endtask

    // Monitor: per-cycle sat_count tracking plus ordered compare of every output beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_sat = 0;
            end else begin
                checkOutput("sat_count", sat_count, model_sat);
                mon_flag = 1'b0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_beat", 1, 0);
                    end else begin
                        mon_e = sb[0];
                        checkOutput("pixel_out", pixel_out, mon_e.pix);
                        checkOutput("out_eol", out_eol, mon_e.eol);
                        checkOutput("out_eof", out_eof, mon_e.eof);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            mon_flag = mon_e.sat;
                            if (out_eol) eol_seen++;
                            if (out_eof) eof_seen++;
                        end
                    end
                end else begin
                    checkOutput("idle_eol", out_eol, 0);
                    checkOutput("idle_eof", out_eof, 0);
                end
                if (clear_stats) model_sat = 0;
                else if (mon_flag && model_sat != 65535) model_sat++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int braw;
        int b;
        int pix;
        int op;
        int sh;
        int r;

        pixel_in    = '0;
        operation   = '0;
        bias        = '0;
        shift       = '0;
        in_valid    = 1'b0;
        clear_stats = 1'b0;
        out_ready   = 1'b1;
        rst         = 1'b1;

        do_reset();
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_pixel_out", pixel_out, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_eol", out_eol, 0);
        checkOutput("reset_eof", out_eof, 0);
        checkOutput("reset_sat_count", sat_count, 0);
        @(posedge clk);
        #1;

        $display("[TB] conv rounding and latency");
        applyStimulus(1000, 0, -200, 2);
        @(negedge clk);
        checkOutput("latency_n1_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_n2_valid", out_valid, 1);
        checkOutput("conv_round_pix", pixel_out, 200);
        @(posedge clk);
        #1;
        drain();
        checkOutput("round_sat_count", sat_count, 0);

        $display("[TB] relu clamp");
        applyAndWatch("relu_pix", 100, 0, -300, 0, 0);
        drain();
        checkOutput("relu_sat_count", sat_count, 0);

        $display("[TB] saturation and clear");
        applyAndWatch("sat_pix", 'h8EE09, 0, 0, 4, 255);
        drain();
        checkOutput("sat_count_one", sat_count, 1);
        out_ready = 1'b0;
        applyStimulus('h8EE09, 0, 0, 4);
        @(posedge clk);
        #1;
        checkOutput("sat_beat_stalled", out_valid, 1);
        out_ready   = 1'b1;
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        checkOutput("sat_clear_wins", sat_count, 0);
        drain();

        $display("[TB] maxpool bypass");
        applyAndWatch("maxpool_pix", 200, 1, -100, 3, 200);
        applyAndWatch("maxpool_sat_pix", 300, 1, 0, 0, 255);
        drain();
        checkOutput("maxpool_sat_count", sat_count, 1);

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 1; i <= 10; i++) applyStimulus(i, 0, 0, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                checkOutput("in_ready_stalled", in_ready, 0);
                checkOutput("held_valid", out_valid, 1);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] framing");
        do_reset();
        eol_seen = 0;
        eof_seen = 0;
        for (int i = 0; i < 8; i++) applyStimulus(10 + i, 0, 0, 0);
        drain();
        checkOutput("frame_eol_count", eol_seen, 2);
        checkOutput("frame_eof_count", eof_seen, 1);
        applyStimulus(50, 0, 0, 0);
        applyStimulus(51, 0, 0, 0);
        applyStimulus(52, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stale_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        eol_seen = 0;
        eof_seen = 0;
        for (int i = 0; i < 4; i++) applyStimulus(60 + i, 0, 0, 0);
        drain();
        checkOutput("post_reset_eol_count", eol_seen, 1);
        checkOutput("post_reset_eof_count", eof_seen, 0);

        $display("[TB] randomized traffic");
        fork
            begin
                while (!stop_random) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    r  = $urandom_range(0, 9);
                    op = (r < 7) ? 0 : (r < 9) ? 1 : $urandom_range(2, 3);
                    pix = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095)
                                                      : $urandom_range(0, 20'hFFFFF);
                    if ($urandom_range(0, 1) == 1) begin
                        b = $urandom_range(0, 2000) - 1000;
                    end else begin
                        braw = $urandom_range(0, (1 << 21) - 1);
                        b    = (braw >= (1 << 20)) ? braw - (1 << 21) : braw;
                    end
                    sh = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 31);
                    clear_stats = ($urandom_range(0, 40) == 0);
                    applyStimulus(pix, op, b, sh);
                    if ($urandom_range(0, 5) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                clear_stats = 1'b0;
                stop_random = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        checkOutput("final_queue_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
